// File: rtl/anode_capture.sv
// Purpose : recover the four digit patterns of a multiplexed 7-segment display
//           by watching its anode/cathode pins and capturing each stable window.
// Latency : pins held before edge k appear on digits after edge k+1+STABLE_CYCLES.
// Backpr. : none; a passive observer that never stalls the scan logic it watches.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   reset      in   synchronous active-high reset
//   an[3:0]    in   active-low one-hot anode lines
//   seg[6:0]   in   active-low cathodes, seg[0]=a .. seg[6]=g
//   dp         in   active-low decimal point
//   digits     out  captured patterns, active-high, digit k at [8k+7:8k] = {dp,g..a}
//   idx        out  index of the most recently captured digit
//   en_out     out  stable sample is a legal one-hot anode that has been captured
//   frame_done out  one-cycle pulse once all four digits have been captured
//   err        out  one-cycle pulse when a stable anode pattern is illegal
//   stale      out  level, no capture for TIMEOUT_CYCLES cycles
module anode_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [31:0] digits,
  output logic [1:0]  idx,
  output logic        en_out,
  output logic        frame_done,
  output logic        err,
  output logic        stale
);

  // Stability threshold fits 8 bits (up to 255), timeout fits 16 bits.
  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] TMO_MAX     = 16'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } sample_t;

  // Everything dark: no anode selected, all cathodes off.
  localparam sample_t BLANK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Input stage and its one-cycle-older copy used for change detection.
  sample_t     smp_q;
  sample_t     prev_q;

  state_t      state_q;
  logic [7:0]  stab_q;
  logic [7:0]  stab_d;
  logic [15:0] tmo_q;
  logic [15:0] tmo_d;

  logic [31:0] digits_q;
  logic [1:0]  idx_q;
  logic [3:0]  seen_q;
  logic        en_q;
  logic        fd_q;
  logic        err_q;
  logic        stale_q;

  // Decode of the registered sample.
  logic        changed;
  logic        smp_blank;
  logic        an_vld;
  logic [1:0]  an_idx;
  logic        reach;
  logic        do_cap;
  logic [3:0]  seen_set;
  logic        frame_full;

  assign changed   = (smp_q != prev_q);
  assign smp_blank = (smp_q.an == 4'hF);

  always_comb begin
    an_vld = 1'b1;
    an_idx = 2'd0;
    case (smp_q.an)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_vld = 1'b0;
    endcase
  end

  // Stability counter: restarts on any difference, saturates at the threshold.
  always_comb begin
    stab_d = stab_q;
    if (changed) begin
      stab_d = 8'd0;
    end else if (stab_q != STABLE_MAX) begin
      stab_d = stab_q + 8'd1;
    end
  end

  // The window is acted on in the same edge the counter reaches the threshold,
  // so the settled value lands on digits one edge after the last needed sample.
  assign reach      = (state_q == SETTLE) && !changed && (stab_q == STABLE_LAST);
  assign do_cap     = reach && an_vld;
  assign seen_set   = seen_q | (4'b0001 << an_idx);
  assign frame_full = (seen_set == 4'hF);

  // Timeout counter: a capture wins over saturation in the same cycle.
  always_comb begin
    tmo_d = tmo_q;
    if (do_cap) begin
      tmo_d = 16'd0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q    <= BLANK;
      prev_q   <= BLANK;
      state_q  <= IDLE;
      stab_q   <= 8'd0;
      tmo_q    <= 16'd0;
      digits_q <= 32'd0;
      idx_q    <= 2'd0;
      seen_q   <= 4'd0;
      en_q     <= 1'b0;
      fd_q     <= 1'b0;
      err_q    <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      smp_q   <= sample_t'({an, seg, dp});
      prev_q  <= smp_q;
      stab_q  <= stab_d;
      tmo_q   <= tmo_d;
      stale_q <= (tmo_d == TMO_MAX);
      fd_q    <= 1'b0;
      err_q   <= 1'b0;

      if (changed) begin
        // A new sample opens a fresh window; blank samples are never acted on.
        state_q <= smp_blank ? IDLE : SETTLE;
        en_q    <= 1'b0;
      end else if (reach) begin
        // Exactly one action per stable window, then wait for the next change.
        state_q <= HOLD;
        if (an_vld) begin
          digits_q[{an_idx, 3'b000} +: 8] <= ~{smp_q.dp, smp_q.seg};
          idx_q <= an_idx;
          en_q  <= 1'b1;
          if (frame_full) begin
            // The completing capture counts toward this frame; start afresh.
            seen_q <= 4'd0;
            fd_q   <= 1'b1;
          end else begin
            seen_q <= seen_set;
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign digits     = digits_q;
  assign idx        = idx_q;
  assign en_out     = en_q;
  assign frame_done = fd_q;
  assign err        = err_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_anode_capture.sv
// Purpose : self-checking bench for anode_capture against a pin-history model.
// Latency : every output compared one time step after each rising edge.
// Backpr. : not applicable; the bench drives pins freely.
module tb_anode_capture;

  localparam int STABLE = 4;
  localparam int TMO    = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [31:0] digits;
  logic [1:0]  idx;
  logic        en_out;
  logic        frame_done;
  logic        err;
  logic        stale;

  always #5 clk = ~clk;

  anode_capture #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .digits    (digits),
    .idx       (idx),
    .en_out    (en_out),
    .frame_done(frame_done),
    .err       (err),
    .stale     (stale)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int fd_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference model: reasons about runs of identical pin samples. A run of
  // STABLE+1 identical non-blank samples triggers one action on the next edge.
  logic [11:0] m_prev;
  logic [11:0] m_pend_smp;
  logic        m_pend;
  int          m_run_len;
  int          m_run_id = 0;
  int          m_en_run;
  logic [31:0] m_digits;
  logic [1:0]  m_idx;
  logic [3:0]  m_seen;
  logic        m_fd;
  logic        m_err;
  logic        m_en;
  logic        m_stale;
  int          m_tmo;

  task automatic model_edge();
    logic [11:0] cur;
    logic [3:0]  a;
    int          k;
    bit          cap;
    cur = {an, seg, dp};
    if (reset) begin
      m_digits = 0; m_idx = 0; m_seen = 0; m_fd = 0; m_err = 0; m_en = 0;
      m_stale = 0; m_tmo = 0; m_prev = 12'hFFF; m_run_len = 1; m_run_id++;
      m_en_run = -1; m_pend = 0;
    end else begin
      m_fd = 0;
      m_err = 0;
      cap = 0;
      if (m_pend) begin
        a = m_pend_smp[11:8];
        if ($countones(~a) == 1) begin
          k = 0;
          for (int b = 0; b < 4; b++) if (!a[b]) k = b;
          m_digits[8*k +: 8] = ~{m_pend_smp[0], m_pend_smp[7:1]};
          m_idx = 2'(k);
          m_seen = m_seen | 4'(1 << k);
          if (m_seen == 4'hF) begin
            m_fd = 1;
            m_seen = 0;
          end
          m_en_run = m_run_id;
          cap = 1;
        end else begin
          m_err = 1;
        end
        m_pend = 0;
      end
      if (cap) m_tmo = 0;
      else if (m_tmo < TMO) m_tmo++;
      m_stale = (m_tmo == TMO);
      m_en = (m_en_run == m_run_id);
      if (cur == m_prev) m_run_len++;
      else begin
        m_run_len = 1;
        m_run_id++;
      end
      m_prev = cur;
      if (m_run_len == STABLE + 1 && cur[11:8] != 4'hF) begin
        m_pend = 1;
        m_pend_smp = cur;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("digits", digits, m_digits);
    chk("idx", {30'd0, idx}, {30'd0, m_idx});
    chk("en_out", {31'd0, en_out}, {31'd0, m_en});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("stale", {31'd0, stale}, {31'd0, m_stale});
    if (frame_done) fd_cnt++;
    if (err) err_cnt++;
  endtask

  // pat is the active-high {dp,g..a} pattern; pins are its complement.
  task automatic drive(input logic [3:0] a, input logic [7:0] pat);
    an  = a;
    seg = ~pat[6:0];
    dp  = ~pat[7];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'hF, 8'h00);
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pats [4];
    logic [3:0] a;
    logic [7:0] p;
    int         len;
    pats[0] = 8'h3F; pats[1] = 8'h06; pats[2] = 8'h5B; pats[3] = 8'h4F;

    // Single digit: visible exactly after the sixth sampling edge.
    do_reset();
    chk("rst_digits", digits, 32'd0);
    chk("rst_flags", {28'd0, en_out, frame_done, err, stale}, 32'd0);
    drive(4'b1110, 8'h06);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 4) chk("t1_before", {24'd0, digits[7:0]}, 32'h00);
    end
    chk("t1_digit", {24'd0, digits[7:0]}, 32'h06);
    chk("t1_idx", {30'd0, idx}, 32'd0);
    chk("t1_en", {31'd0, en_out}, 32'd1);
    chk("t1_err", {31'd0, err}, 32'd0);

    // Full scan of four digits: one frame pulse.
    do_reset();
    fd_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      a = ~(4'b0001 << d);
      drive(a, pats[d]);
      repeat (8) step();
    end
    drive(4'hF, 8'h00);
    repeat (2) step();
    chk("t2_digits", digits, 32'h4F5B063F);
    chk("t2_frames", fd_cnt, 1);

    // Illegal anode: one err pulse, nothing written; then a short glitch.
    err_cnt = 0;
    drive(4'b1100, 8'h7F);
    repeat (8) step();
    chk("t3_errs", err_cnt, 1);
    chk("t3_digits", digits, 32'h4F5B063F);
    chk("t3_en", {31'd0, en_out}, 32'd0);
    drive(4'b1101, 8'h77);
    repeat (3) step();
    drive(4'hF, 8'h00);
    repeat (6) step();
    chk("t3_glitch_digits", digits, 32'h4F5B063F);
    chk("t3_glitch_idx", {30'd0, idx}, 32'd3);
    chk("t3_glitch_errs", err_cnt, 1);

    // Timeout: stale rises on the TMO-th idle edge, cleared by a capture.
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == TMO - 1) chk("t4_stale_early", {31'd0, stale}, 32'd0);
      if (i == TMO) chk("t4_stale_rise", {31'd0, stale}, 32'd1);
    end
    drive(4'b1110, 8'h5B);
    repeat (6) step();
    chk("t4_stale_clear", {31'd0, stale}, 32'd0);
    chk("t4_digit", {24'd0, digits[7:0]}, 32'h5B);

    // Reset two cycles into a settle window discards it.
    do_reset();
    drive(4'b1011, 8'h4F);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(4'hF, 8'h00);
    chk("t5_rst_digits", digits, 32'd0);
    chk("t5_rst_flags", {26'd0, idx, en_out, frame_done, err, stale}, 32'd0);
    repeat (8) step();
    chk("t5_nocap", digits, 32'd0);

    // Randomized segments of varying length, mixing glitches and resets.
    for (int s = 0; s < 450; s++) begin
      len = $urandom_range(1, 10);
      p = 8'($urandom);
      case ($urandom_range(0, 99)) inside
        [0:69]:  a = ~(4'b0001 << $urandom_range(0, 3));
        [70:84]: a = 4'hF;
        default: a = 4'($urandom);
      endcase
      drive(a, p);
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      repeat (len) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/anode_capture.md
ANODE_CAPTURE -- requirements
Module: anode_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive cycles an anode/segment sample must stay unchanged before capture (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: cycles without a capture before the stale flag asserts (16-bit counter).
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port an  input  4  active-low one-hot anode lines driven by the display scan logic.
REQ-006 SHALL have port seg  input  7  active-low cathodes, seg[0]=a ... seg[6]=g.
REQ-007 SHALL have port dp  input  1  active-low decimal point.
REQ-008 SHALL have port digits  output  32  captured patterns, active-high; digit k at [8k+7:8k] as {dp,g,f,e,d,c,b,a}.
REQ-009 SHALL have port idx  output  2  encoded index of the most recently captured digit.
REQ-010 SHALL have port en_out  output  1  high while the stable registered anode sample is legal one-hot (reconstructed enable).
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when all four digits captured since last pulse.
REQ-012 SHALL have port err  output  1  one-cycle pulse on a stable illegal anode pattern.
REQ-013 SHALL have port stale  output  1  level; high when no capture for TIMEOUT_CYCLES cycles.

Function
REQ-014 SHALL register {an,seg,dp} through one input stage; all decisions use the registered sample.
REQ-015 SHALL encode anode: 1110->0, 1101->1, 1011->2, 0111->3; 1111 = blank; any other value = illegal.
REQ-016 SHALL keep a stability counter cleared whenever the registered sample differs from its previous value, incremented otherwise, saturating at STABLE_CYCLES.
REQ-017 SHALL implement states IDLE (blank sample), SETTLE (counting), HOLD (window already acted on); any sample change returns to SETTLE, or IDLE if new sample is blank.
REQ-018 SHALL, on SETTLE reaching STABLE_CYCLES with a legal anode, write ~{dp,seg} into digit idx, update idx, set seen[idx], go to HOLD; exactly one capture per stable window.
REQ-019 SHALL make a pattern held constant on the pins from before edge k visible on digits after edge k+1+STABLE_CYCLES.
REQ-020 SHALL, on SETTLE reaching STABLE_CYCLES with an illegal anode, pulse err for one cycle, write nothing, go to HOLD.
REQ-021 SHALL never capture or flag while blank; en_out=0 in IDLE and for illegal samples.
REQ-022 SHALL pulse frame_done in the cycle after the capture that makes seen=1111, clearing seen in the same update (that capture counted).
REQ-023 SHALL ignore glitches shorter than STABLE_CYCLES: no digit, idx, seen or err change.
REQ-024 SHALL recapture the same digit if re-selected after a change; latest value wins, seen unaffected if already set.
REQ-025 SHALL clear the timeout counter on every capture, increment otherwise, saturate at TIMEOUT_CYCLES; stale=1 while saturated, cleared on the next capture.
REQ-026 SHALL give capture precedence over timeout saturation in the same cycle (stale stays 0).

Reset
REQ-027 SHALL on reset set digits=0, idx=0, en_out=0, frame_done=0, err=0, stale=0, seen=0000, counters=0, state=IDLE, input stage to blank (an=1111, seg=7F, dp=1).
REQ-028 SHALL discard any in-progress settle window when reset asserts mid-operation; no capture results from it.

Verification
REQ-029 SHALL verify: an=1110, seg=7'b1111001, dp=1 held 6 cycles -> digits[7:0]=8'h06 after edge 5, idx=0, en_out=1, no err.
REQ-030 SHALL verify: scan digits 0..3 with patterns 8'h3F,8'h06,8'h5B,8'h4F each held 8 cycles -> digits=32'h4F5B063F, one frame_done pulse after digit 3 capture.
REQ-031 SHALL verify: an=1100 held 8 cycles -> one err pulse, digits unchanged, en_out=0; 3-cycle an=1101 glitch -> no change.
REQ-032 SHALL verify: TIMEOUT_CYCLES=20, an=1111 for 30 cycles -> stale rises at cycle 20; then a legal capture clears it.
REQ-033 SHALL verify: reset asserted 2 cycles into a settle window -> all outputs zero, no capture from that window.
